// File: rtl/serial_adder_ctrl_if.sv
// Handshake/operand bundle for the bit-serial adder: the requester drives the
// operands and start, the adder returns status and the registered result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands are latched on start, then one full-adder
// slice consumes one bit per clock, LSB first, and the result is posted with a done pulse.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             c_reg;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] acc_nxt;

  // Full adder built from two half adders; returns {carry, sum}.
  function automatic logic [1:0] fa_with_ha(input logic x, input logic y, input logic ci);
    logic s1, c1, c2;
    s1 = x ^ y;
    c1 = x & y;
    c2 = s1 & ci;
    return {c1 | c2, s1 ^ ci};
  endfunction

  // New bit enters at the MSB; written as shifts so WIDTH=1 needs no empty slice.
  always_comb begin
    {c_bit, s_bit} = fa_with_ha(a_sr[0], b_sr[0], c_reg);
    acc_nxt = (acc >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      acc     <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      carry_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            c_reg  <= bus.carry_in;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= acc_nxt;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          c_reg <= c_bit;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_r   <= acc_nxt;
            carry_r <= c_bit;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            c_reg  <= bus.carry_in;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboarded bench for the bit-serial adder: WIDTH=8 main instance plus a
// WIDTH=1 instance for the single-cycle corner.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] sb[$];
  logic [8:0] exp_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_r = sb.pop_front();
        check("result", {23'd0, bus.carry_out, bus.sum}, {23'd0, exp_r});
      end
    end
  end

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, input bit push);
    @(negedge clk);
    bus.a        = ta;
    bus.b        = tb_v;
    bus.carry_in = tc;
    bus.start    = 1'b1;
    if (push) sb.push_back({1'b0, ta} + {1'b0, tb_v} + {8'd0, tc});
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
  endtask

  // Counts edges until done is seen, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, exp_edges);
  endtask

  task automatic step_out;
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.carry_in = 1'b0;

    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", {23'd0, bus.carry_out, bus.sum}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: zero operands
    launch(8'h00, 8'h00, 1'b0, 1'b1);
    wait_done("latency_t1", 8);
    check("busy_in_done", {31'd0, bus.busy}, 32'd0);
    step_out();

    // 2: full carry ripple
    launch(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done("latency_t2", 8);
    step_out();
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // 3: back-to-back with start held through DONE
    launch(8'h5A, 8'h25, 1'b1, 1'b1);
    wait_done("latency_t3a", 8);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.carry_in = 1'b1; bus.start = 1'b1;
    sb.push_back(9'h1FF);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    check("b2b_done_low", {31'd0, bus.done}, 32'd0);
    check("b2b_hold", {23'd0, bus.carry_out, bus.sum}, 32'h080);
    wait_done("latency_t3b", 8);
    step_out();

    // 4: start during SHIFT is ignored
    launch(8'h12, 8'h34, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.carry_in = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("hold_mid_shift", {23'd0, bus.carry_out, bus.sum}, 32'h1FF);
    wait_done("latency_t4", 5);
    step_out();
    repeat (3) @(posedge clk);
    #1;
    check("no_second_op", {31'd0, bus.busy}, 32'd0);

    // 5: async reset mid-operation
    launch(8'h5A, 8'h25, 1'b1, 1'b1);
    wait_done("latency_t5a", 8);
    step_out();
    launch(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_result", {23'd0, bus.carry_out, bus.sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_idle", {30'd0, bus.busy, bus.done}, 32'd0);
    launch(8'h0F, 8'h01, 1'b0, 1'b1);
    wait_done("latency_t5b", 8);
    step_out();

    // 6: WIDTH=1 instance
    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.carry_in = 1'b1; bus1.start = 1'b1;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    check("w1_busy", {31'd0, bus1.busy}, 32'd1);
    @(posedge clk);
    #1;
    check("w1_done", {31'd0, bus1.done}, 32'd1);
    check("w1_result", {30'd0, bus1.carry_out, bus1.sum}, 32'd3);
    @(posedge clk);
    #1;
    check("w1_done_pulse", {31'd0, bus1.done}, 32'd0);

    repeat (2) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
